// File: rtl/rx_header_parser_if.sv
// AXI-Stream bundle used for both the receive-side packet input and the
// payload output of rx_header_parser.
interface rx_header_parser_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rx_header_parser.sv
// Strips and validates the fixed 7-beat RDMA header from a receive stream,
// publishes the decoded fields and forwards only the payload.
module rx_header_parser #(
  parameter int          C_AXIS_TDATA_WIDTH = 32,
  parameter int          C_AXIS_TKEEP_WIDTH = 4,
  parameter int          HEADER_BEATS       = 7,
  parameter logic [23:0] HDR_MAGIC          = 24'hABABAB
) (
  input  logic               aclk,
  input  logic               areset,
  rx_header_parser_if.slave  s_axis,
  rx_header_parser_if.master m_axis,
  output logic [7:0]         rdma_opcode,
  output logic [23:0]        rdma_psn,
  output logic [23:0]        rdma_dest_qp,
  output logic [63:0]        rdma_remote_addr,
  output logic [15:0]        fragment_offset,
  output logic [31:0]        rdma_length,
  output logic [15:0]        rdma_partition_key,
  output logic [7:0]         rdma_service_level,
  output logic               hdr_valid,
  output logic               hdr_error,
  output logic               len_error,
  output logic               rx_done,
  output logic               rx_busy
);

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_DATA   = 2'd1,
    ST_DROP   = 2'd2
  } state_e;

  localparam logic [2:0] LAST_BEAT = 3'(HEADER_BEATS - 1);

  function automatic logic [31:0] keep_bytes(input logic [C_AXIS_TKEEP_WIDTH-1:0] keep);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
      n = n + {31'd0, keep[i]};
    end
    return n;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] byte_sum_s;
  logic        commit_s;
  logic        s_hs_s;

  logic [C_AXIS_TDATA_WIDTH-1:0] s_tdata_s;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_tdata_s;
  logic [C_AXIS_TKEEP_WIDTH-1:0] m_tkeep_s;
  logic                          m_tvalid_s;
  logic                          m_tlast_s;
  logic                          s_tready_s;

  logic        hdr_valid_q, hdr_valid_d;
  logic        hdr_error_q, hdr_error_d;
  logic        len_error_q, len_error_d;
  logic        rx_done_q, rx_done_d;
  logic        rx_busy_q, rx_busy_d;

  // Shadow copies of header beats 0..5, held until the magic check commits them.
  logic [7:0]  sh_opcode_q;
  logic [23:0] sh_psn_q;
  logic [23:0] sh_qp_q;
  logic [31:0] sh_addr_q;
  logic [15:0] sh_foff_q;
  logic [31:0] sh_len_q;
  logic [15:0] sh_pkey_q;

  logic [7:0]  opcode_q;
  logic [23:0] psn_q;
  logic [23:0] qp_q;
  logic [31:0] addr_q;
  logic [15:0] foff_q;
  logic [31:0] length_q;
  logic [15:0] pkey_q;
  logic [7:0]  sl_q;

  assign s_tdata_s = s_axis.tdata;
  assign s_hs_s    = s_axis.tvalid & s_tready_s;

  always_comb begin
    s_tready_s = 1'b1;
    m_tvalid_s = 1'b0;
    m_tdata_s  = {C_AXIS_TDATA_WIDTH{1'b0}};
    m_tkeep_s  = {C_AXIS_TKEEP_WIDTH{1'b0}};
    m_tlast_s  = 1'b0;
    if (state_q == ST_DATA) begin
      s_tready_s = m_axis.tready;
      m_tvalid_s = s_axis.tvalid;
      m_tdata_s  = s_tdata_s;
      m_tkeep_s  = s_axis.tkeep;
      m_tlast_s  = s_axis.tlast;
    end else begin
      s_tready_s = 1'b1;
    end
  end

  assign s_axis.tready = s_tready_s;
  assign m_axis.tvalid = m_tvalid_s;
  assign m_axis.tdata  = m_tdata_s;
  assign m_axis.tkeep  = m_tkeep_s;
  assign m_axis.tlast  = m_tlast_s;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    commit_s    = 1'b0;
    hdr_valid_d = 1'b0;
    hdr_error_d = 1'b0;
    len_error_d = 1'b0;
    rx_done_d   = 1'b0;
    byte_sum_s  = byte_cnt_q + keep_bytes(s_axis.tkeep);
    case (state_q)
      ST_HEADER: begin
        if (s_hs_s) begin
          if (s_axis.tlast) begin
            hdr_error_d = 1'b1;
            beat_cnt_d  = 3'd0;
          end else if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = 3'd0;
            if (s_tdata_s[31:8] == HDR_MAGIC) begin
              commit_s    = 1'b1;
              hdr_valid_d = 1'b1;
              byte_cnt_d  = 32'd0;
              state_d     = ST_DATA;
            end else begin
              hdr_error_d = 1'b1;
              state_d     = ST_DROP;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
      ST_DATA: begin
        if (s_hs_s) begin
          byte_cnt_d = byte_sum_s;
          if (s_axis.tlast) begin
            rx_done_d   = 1'b1;
            len_error_d = (byte_sum_s != length_q);
            state_d     = ST_HEADER;
            beat_cnt_d  = 3'd0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
      end
      ST_DROP: begin
        if (s_hs_s && s_axis.tlast) begin
          state_d    = ST_HEADER;
          beat_cnt_d = 3'd0;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d    = ST_HEADER;
        beat_cnt_d = 3'd0;
      end
    endcase
    rx_busy_d = (state_d != ST_HEADER) || (beat_cnt_d != 3'd0);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_HEADER;
      beat_cnt_q  <= 3'd0;
      byte_cnt_q  <= 32'd0;
      hdr_valid_q <= 1'b0;
      hdr_error_q <= 1'b0;
      len_error_q <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_error_q <= hdr_error_d;
      len_error_q <= len_error_d;
      rx_done_q   <= rx_done_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sh_opcode_q <= 8'd0;
      sh_psn_q    <= 24'd0;
      sh_qp_q     <= 24'd0;
      sh_addr_q   <= 32'd0;
      sh_foff_q   <= 16'd0;
      sh_len_q    <= 32'd0;
      sh_pkey_q   <= 16'd0;
    end else if (state_q == ST_HEADER && s_hs_s) begin
      case (beat_cnt_q)
        3'd0: begin
          sh_opcode_q <= s_tdata_s[7:0];
          sh_psn_q    <= s_tdata_s[31:8];
        end
        3'd1: sh_qp_q   <= s_tdata_s[23:0];
        3'd2: sh_addr_q <= s_tdata_s[31:0];
        3'd3: sh_foff_q <= s_tdata_s[15:0];
        3'd4: sh_len_q  <= s_tdata_s[31:0];
        3'd5: sh_pkey_q <= s_tdata_s[15:0];
        default: sh_pkey_q <= sh_pkey_q;
      endcase
    end
  end

  // All fields update together on commit so downstream never sees a mixed header.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      opcode_q <= 8'd0;
      psn_q    <= 24'd0;
      qp_q     <= 24'd0;
      addr_q   <= 32'd0;
      foff_q   <= 16'd0;
      length_q <= 32'd0;
      pkey_q   <= 16'd0;
      sl_q     <= 8'd0;
    end else if (commit_s) begin
      opcode_q <= sh_opcode_q;
      psn_q    <= sh_psn_q;
      qp_q     <= sh_qp_q;
      addr_q   <= sh_addr_q;
      foff_q   <= sh_foff_q;
      length_q <= sh_len_q;
      pkey_q   <= sh_pkey_q;
      sl_q     <= s_tdata_s[7:0];
    end
  end

  assign rdma_opcode        = opcode_q;
  assign rdma_psn           = psn_q;
  assign rdma_dest_qp       = qp_q;
  assign rdma_remote_addr   = {32'h0000_0000, addr_q};
  assign fragment_offset    = foff_q;
  assign rdma_length        = length_q;
  assign rdma_partition_key = pkey_q;
  assign rdma_service_level = sl_q;
  assign hdr_valid          = hdr_valid_q;
  assign hdr_error          = hdr_error_q;
  assign len_error          = len_error_q;
  assign rx_done            = rx_done_q;
  assign rx_busy            = rx_busy_q;

endmodule

// File: tb/tb_rx_header_parser.sv
// Randomized bench for rx_header_parser: packets are described at header/payload
// level and the expected outputs are derived per packet from the parsing rules.
module tb_rx_header_parser;

  localparam logic [23:0] MAGIC = 24'hABABAB;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  rx_header_parser_if #(.DW(32)) s_if ();
  rx_header_parser_if #(.DW(32)) m_if ();

  logic [7:0]  rdma_opcode;
  logic [23:0] rdma_psn;
  logic [23:0] rdma_dest_qp;
  logic [63:0] rdma_remote_addr;
  logic [15:0] fragment_offset;
  logic [31:0] rdma_length;
  logic [15:0] rdma_partition_key;
  logic [7:0]  rdma_service_level;
  logic        hdr_valid, hdr_error, len_error, rx_done, rx_busy;

  rx_header_parser dut (
    .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if),
    .rdma_opcode(rdma_opcode), .rdma_psn(rdma_psn), .rdma_dest_qp(rdma_dest_qp),
    .rdma_remote_addr(rdma_remote_addr), .fragment_offset(fragment_offset),
    .rdma_length(rdma_length), .rdma_partition_key(rdma_partition_key),
    .rdma_service_level(rdma_service_level), .hdr_valid(hdr_valid),
    .hdr_error(hdr_error), .len_error(len_error), .rx_done(rx_done), .rx_busy(rx_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus stream and expectations
  bit [31:0] sd[$];
  bit [3:0]  sk[$];
  bit        sl[$];
  bit        sfirst[$];
  bit [36:0] exp_out[$];
  int exp_hv, exp_he, exp_le, exp_done;
  bit [7:0]  e_op;   bit [23:0] e_psn;  bit [23:0] e_qp;  bit [31:0] e_addr;
  bit [15:0] e_foff; bit [31:0] e_len;  bit [15:0] e_pkey; bit [7:0] e_sl;

  // Observations (cumulative, only written by the monitor)
  bit [36:0] obs_out[$];
  int obs_hv = 0, obs_he = 0, obs_le = 0, obs_done = 0;
  int obs_mvalid = 0, obs_mirror_bad = 0, obs_orphan = 0;
  int base_out, base_hv, base_he, base_le, base_done, base_mvalid, base_mirror, base_orphan;

  int  rdy_mode = 0;
  bit  gaps = 1'b0;

  always @(negedge aclk) begin
    if (!areset) begin
      if (m_if.tvalid && m_if.tready) obs_out.push_back({m_if.tlast, m_if.tkeep, m_if.tdata});
      if (m_if.tvalid) begin
        obs_mvalid++;
        if (s_if.tready !== m_if.tready) obs_mirror_bad++;
      end
      if (hdr_valid) obs_hv++;
      if (hdr_error) obs_he++;
      if (len_error) obs_le++;
      if (rx_done) obs_done++;
      if (len_error && !rx_done) obs_orphan++;
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0: m_if.tready = 1'b1;
        1: m_if.tready = ~m_if.tready;
        default: m_if.tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic sync_expect();
    sd.delete(); sk.delete(); sl.delete(); sfirst.delete(); exp_out.delete();
    exp_hv = 0; exp_he = 0; exp_le = 0; exp_done = 0;
    base_out = obs_out.size(); base_hv = obs_hv; base_he = obs_he; base_le = obs_le;
    base_done = obs_done; base_mvalid = obs_mvalid; base_mirror = obs_mirror_bad;
    base_orphan = obs_orphan;
  endtask

  task automatic push_beat(input bit [31:0] d, input bit [3:0] k, input bit l, input bit f);
    sd.push_back(d); sk.push_back(k); sl.push_back(l); sfirst.push_back(f);
  endtask

  task automatic add_packet(input bit [7:0] op, input bit [23:0] psn, input bit [23:0] qp,
                            input bit [31:0] addr, input bit [15:0] foff, input bit [31:0] len,
                            input bit [15:0] pkey, input bit [31:0] b6, input int npay,
                            input bit [3:0] lastkeep, input int trunc_at, input bit rnd);
    bit [31:0] h [7];
    bit [31:0] d;
    bit [3:0]  k;
    bit        good;
    int        bytes;
    h[0] = {psn, op};
    h[1] = {8'($urandom), qp};
    h[2] = addr;
    h[3] = {16'($urandom), foff};
    h[4] = len;
    h[5] = {16'($urandom), pkey};
    h[6] = b6;
    if (trunc_at >= 0) begin
      for (int i = 0; i <= trunc_at; i++) push_beat(h[i], 4'hF, i == trunc_at, i == 0);
      exp_he++;
    end else begin
      good  = (b6[31:8] == MAGIC);
      bytes = 0;
      for (int i = 0; i < 7; i++) push_beat(h[i], 4'hF, 1'b0, i == 0);
      for (int i = 0; i < npay; i++) begin
        d = rnd ? 32'($urandom) : 32'hA0 + 32'(i);
        k = (i == npay - 1) ? lastkeep : 4'hF;
        push_beat(d, k, i == npay - 1, 1'b0);
        bytes += $countones(k);
        if (good) exp_out.push_back({i == npay - 1, k, d});
      end
      if (good) begin
        exp_hv++; exp_done++;
        if (32'(bytes) != len) exp_le++;
        e_op = op; e_psn = psn; e_qp = qp; e_addr = addr; e_foff = foff;
        e_len = len; e_pkey = pkey; e_sl = b6[7:0];
      end else begin
        exp_he++;
      end
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send_beat(input string tag, input int i, output bit ok);
    int budget;
    bit hs;
    s_if.tvalid = 1'b1; s_if.tdata = sd[i]; s_if.tkeep = sk[i]; s_if.tlast = sl[i];
    budget = 0; hs = 1'b0;
    while (!hs && budget < 200) begin
      @(negedge aclk); hs = s_if.tready;
      @(posedge aclk); #1;
      budget++;
    end
    ok = hs;
    if (!hs) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    else if (sfirst[i]) check_val({tag, "_busy_start"}, {63'd0, rx_busy}, {63'd0, !sl[i]});
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_if.tvalid = 1'b0; s_if.tdata = $urandom;
      repeat ($urandom_range(1, 2)) @(posedge aclk);
      #1;
    end
  endtask

  task automatic check_fields(input string tag);
    check_val({tag, "_opcode"}, 64'(rdma_opcode), 64'(e_op));
    check_val({tag, "_psn"}, 64'(rdma_psn), 64'(e_psn));
    check_val({tag, "_qp"}, 64'(rdma_dest_qp), 64'(e_qp));
    check_val({tag, "_addr"}, rdma_remote_addr, {32'h0, e_addr});
    check_val({tag, "_foff"}, 64'(fragment_offset), 64'(e_foff));
    check_val({tag, "_len"}, 64'(rdma_length), 64'(e_len));
    check_val({tag, "_pkey"}, 64'(rdma_partition_key), 64'(e_pkey));
    check_val({tag, "_sl"}, 64'(rdma_service_level), 64'(e_sl));
  endtask

  task automatic run_batch(input string tag);
    bit ok;
    int nobs;
    for (int i = 0; i < sd.size(); i++) begin
      send_beat(tag, i, ok);
      if (!ok) break;
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    nobs = obs_out.size() - base_out;
    check_val({tag, "_nbeats"}, 64'(nobs), 64'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < nobs; i++)
      check_val({tag, "_beat"}, 64'(obs_out[base_out + i]), 64'(exp_out[i]));
    if (exp_out.size() == 0) check_val({tag, "_no_mvalid"}, 64'(obs_mvalid - base_mvalid), 64'd0);
    check_val({tag, "_hdr_valid"}, 64'(obs_hv - base_hv), 64'(exp_hv));
    check_val({tag, "_hdr_error"}, 64'(obs_he - base_he), 64'(exp_he));
    check_val({tag, "_len_error"}, 64'(obs_le - base_le), 64'(exp_le));
    check_val({tag, "_rx_done"}, 64'(obs_done - base_done), 64'(exp_done));
    check_val({tag, "_len_err_align"}, 64'(obs_orphan - base_orphan), 64'd0);
    check_val({tag, "_mirror"}, 64'(obs_mirror_bad - base_mirror), 64'd0);
    check_val({tag, "_busy_end"}, {63'd0, rx_busy}, 64'd0);
    check_fields(tag);
    sync_expect();
  endtask

  task automatic nominal(input bit [31:0] len, input bit [3:0] lastkeep);
    add_packet(8'h0A, 24'h000123, 24'h000011, 32'h1000_0000, 16'h0004, len, 16'hFFFF,
               {MAGIC, 8'h03}, 4, lastkeep, -1, 1'b0);
  endtask

  initial begin
    bit ok;
    int np, kind, npay, tr;
    bit [3:0]  lk;
    bit [31:0] b6, ln;

    s_if.tvalid = 1'b0; s_if.tdata = 32'd0; s_if.tkeep = 4'd0; s_if.tlast = 1'b0;
    areset = 1'b1;
    e_op = 8'd0; e_psn = 24'd0; e_qp = 24'd0; e_addr = 32'd0;
    e_foff = 16'd0; e_len = 32'd0; e_pkey = 16'd0; e_sl = 8'd0;
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    check_val("rst_s_tready", {63'd0, s_if.tready}, 64'd1);
    check_val("rst_busy", {63'd0, rx_busy}, 64'd0);
    check_val("rst_pulses", {60'd0, hdr_valid, hdr_error, len_error, rx_done}, 64'd0);
    check_fields("rst");
    areset = 1'b0;
    sync_expect();

    rdy_mode = 0; nominal(32'd16, 4'hF); run_batch("nominal");
    rdy_mode = 1; nominal(32'd16, 4'hF); run_batch("backpressure");
    rdy_mode = 0;
    add_packet(8'h55, 24'h0000AA, 24'h000022, 32'h2000_0000, 16'h0008, 32'd12, 16'h1234,
               32'h0000_0003, 3, 4'hF, -1, 1'b1);
    run_batch("bad_magic");
    add_packet(8'h21, 24'h000777, 24'h000033, 32'h3000_0040, 16'h0010, 32'd8, 16'h8001,
               {MAGIC, 8'h07}, 2, 4'hF, -1, 1'b1);
    run_batch("after_bad_magic");
    nominal(32'd16, 4'h3); run_batch("len_mismatch");
    add_packet(8'h66, 24'h000001, 24'h000044, 32'h4000_0000, 16'h0000, 32'd4, 16'h0001,
               {MAGIC, 8'h01}, 1, 4'hF, 3, 1'b1);
    run_batch("truncated");
    nominal(32'd16, 4'hF); run_batch("after_trunc");

    // Reset asserted off-edge while payload beat 2 is on the bus
    nominal(32'd16, 4'hF);
    for (int i = 0; i < 9; i++) send_beat("rst_mid", i, ok);
    s_if.tvalid = 1'b1; s_if.tdata = sd[9]; s_if.tkeep = sk[9]; s_if.tlast = sl[9];
    #2 areset = 1'b1;
    #1;
    check_val("rst_mid_m_tvalid", {63'd0, m_if.tvalid}, 64'd0);
    check_val("rst_mid_busy", {63'd0, rx_busy}, 64'd0);
    e_op = 8'd0; e_psn = 24'd0; e_qp = 24'd0; e_addr = 32'd0;
    e_foff = 16'd0; e_len = 32'd0; e_pkey = 16'd0; e_sl = 8'd0;
    check_fields("rst_mid");
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    sync_expect();
    nominal(32'd16, 4'hF); run_batch("after_reset");

    // Random batches of back-to-back packets
    gaps = 1'b1;
    for (int b = 0; b < 40; b++) begin
      rdy_mode = $urandom_range(0, 2);
      np = $urandom_range(1, 3);
      for (int p = 0; p < np; p++) begin
        kind = $urandom_range(0, 9);
        npay = $urandom_range(1, 6);
        lk   = 4'($urandom_range(0, 15));
        b6   = {MAGIC, 8'($urandom)};
        tr   = -1;
        if (kind < 2) tr = $urandom_range(0, 6);
        else if (kind == 2) begin
          b6 = $urandom;
          if (b6[31:8] == MAGIC) b6[31] = ~b6[31];
        end
        ln = 32'(4 * (npay - 1) + $countones(lk));
        if ($urandom_range(0, 1) == 1) ln = $urandom_range(0, 40);
        add_packet(8'($urandom), 24'($urandom), 24'($urandom), $urandom, 16'($urandom),
                   ln, 16'($urandom), b6, npay, lk, tr, 1'b1);
      end
      run_batch("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_header_parser.md
# rx_header_parser

Receive-side counterpart of the RDMA TX header inserter. It consumes an AXI-Stream packet made of a fixed 7-beat, 32-bit RDMA header followed by payload. It strips and validates the header, publishes the decoded fields on control wires, and forwards only the payload on a master AXI-Stream. It sits between the network-side receive stream and the data mover that writes payload to memory.

## Interface
- C_AXIS_TDATA_WIDTH, 32: stream data width; only 32 is supported.
- C_AXIS_TKEEP_WIDTH, 4: TDATA_WIDTH/8.
- HEADER_BEATS, 7: number of header beats per packet.
- HDR_MAGIC, 24'hABABAB: required value of beat 6 bits [31:8].
- aclk  in  1  single clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata / tkeep / tvalid / tlast  in  32/4/1/1  packet input stream.
- s_axis_tready  out  1  input ready.
- m_axis_tdata / tkeep / tvalid / tlast  out  32/4/1/1  payload output stream.
- m_axis_tready  in  1  downstream ready.
- rdma_opcode  out  8  beat0[7:0].
- rdma_psn  out  24  beat0[31:8].
- rdma_dest_qp  out  24  beat1[23:0]; beat1[31:24] is ignored.
- rdma_remote_addr  out  64  {32'h0, beat2}.
- fragment_offset  out  16  beat3[15:0].
- rdma_length  out  32  beat4.
- rdma_partition_key  out  16  beat5[15:0].
- rdma_service_level  out  8  beat6[7:0].
- hdr_valid  out  1  one-cycle pulse: a new header has been committed to the field outputs.
- hdr_error  out  1  one-cycle pulse: header rejected (bad magic or truncated).
- len_error  out  1  one-cycle pulse, coincident with rx_done: payload byte count differs from rdma_length.
- rx_done  out  1  one-cycle pulse after the final payload beat has been transferred.
- rx_busy  out  1  high from the first header handshake until the packet ends.

## Operation
- States:
  - HEADER: s_axis_tready=1 and m_axis_tvalid=0. A 3-bit beat counter counts accepted beats 0..6.
  - DATA: combinational pass-through. s_axis_tready=m_axis_tready, m_axis_tvalid=s_axis_tvalid, and tdata/tkeep/tlast are routed straight through. When not in DATA, m_axis_tdata/tkeep/tlast are 0.
  - DROP: s_axis_tready=1, m_axis_tvalid=0. Beats are discarded until a tlast handshake, then the block returns to HEADER with count 0.
- Header beats 0..5 are captured into shadow registers on their handshakes. The field outputs are not touched until commit.
- Beat 6 handshake with tlast=0:
  - If beat6[31:8]==HDR_MAGIC: all field outputs load simultaneously from the shadow registers plus beat 6. hdr_valid is asserted, the payload byte counter clears, and the block enters DATA.
  - Otherwise: hdr_error is asserted, the field outputs are unchanged, and the block enters DROP.
- Truncated header: a tlast handshake on any header beat 0..6 asserts hdr_error, leaves the fields unchanged, and returns the block to HEADER with count 0.
- DATA byte count:
  - On each output handshake, add popcount(tkeep) to a 32-bit counter. The counter wraps modulo 2^32.
  - On the tlast handshake, compare counter+popcount against rdma_length. Assert rx_done, assert len_error on mismatch, and return to HEADER with count 0.
- Payload is always forwarded regardless of len_error; the flag is informational only.
- rx_busy is high while in HEADER with a nonzero count, and in DATA or DROP.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State is HEADER, the beat counter and byte counter are 0, and every output register and field is 0.
  - m_axis_tvalid drops combinationally with the state.
  - The first beat after reset is treated as header beat 0.
- hdr_valid, hdr_error, len_error, rx_done and rx_busy are registered. Each pulse appears the cycle after the triggering handshake and lasts exactly one cycle.
- Field outputs change on the same edge that raises hdr_valid, and hold until the next hdr_valid.
- Header latency: payload beat 0 can be presented to m_axis in the cycle after the beat-6 handshake.
- Payload path has zero latency: it is combinational. Backpressure from m_axis_tready maps directly onto s_axis_tready.
- Back-to-back packets: the beat after a final payload tlast is accepted as header beat 0 with no bubble.
- The header phase ignores m_axis_tready; header beats are consumed at one per cycle while s_axis_tvalid is high.
- Stalls (tvalid low) inside the header or payload do not change the counters or the state.

## Test plan
- Nominal packet:
  - Stimulus: header opcode 0x0A, psn 0x000123, qp 0x000011, addr 0x10000000, foff 0x0004, len 16, pkey 0xFFFF, sl 0x03, magic OK, then payload beats 0xA0..0xA3 with tkeep 0xF and tlast on beat 3.
  - Required: fields exact, remote_addr upper 32 bits = 0, hdr_valid pulses once, exactly 4 identical payload beats out, rx_done pulses, no len_error.
- Backpressure:
  - Stimulus: same packet, with m_axis_tready toggling 1/0 every cycle during payload.
  - Required: s_axis_tready mirrors m_axis_tready, no beat is lost or duplicated, rx_done pulses after the 4th beat.
- Bad magic:
  - Stimulus: beat6 = 0x00000003, followed by 3 payload beats.
  - Required: hdr_error pulses, m_axis_tvalid stays 0 throughout, s_axis_tready=1, fields keep their previous values. A following good packet parses correctly.
- Length mismatch:
  - Stimulus: len=16, payload of 4 beats with the last tkeep = 0x3 (14 bytes).
  - Required: all 4 beats forwarded, rx_done and len_error pulse in the same cycle.
- Truncated header:
  - Stimulus: tlast asserted on header beat 3.
  - Required: hdr_error pulses, no hdr_valid, nothing on m_axis. The next packet is parsed from beat 0.
- Reset mid-payload:
  - Stimulus: assert areset asynchronously (off-edge) during payload beat 2.
  - Required: m_axis_tvalid, rx_busy and all fields go to 0 immediately. After release, a fresh packet parses correctly.
